// File: rtl/uart_tx_ce_if.sv
// Byte handshake between a producer and the clock-enable driven UART transmitter.
`timescale 1ns/1ps
interface uart_tx_ce_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output out_ready
  );
endinterface

// File: rtl/uart_tx_ce.sv
// UART transmitter whose bit timing advances only on the divider's clock-enable strobe.
// Frame: start, LSB-first data, optional even parity, 1 or 2 stop bits.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | line high, ready for a new byte
//   ST_START  | driving the start bit (low)
//   ST_DATA   | shifting out payload bits, LSB first
//   ST_PARITY | driving the even-parity bit
//   ST_STOP   | driving stop bit(s) high; done pulses at the last end
`timescale 1ns/1ps
module uart_tx_ce #(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 16,
  parameter int PARITY_EN     = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic               in_sys_clk,
  input  logic               in_rst_n,
  input  logic               in_clock_ena,
  uart_tx_ce_if.slave        tx_bus,
  output logic               out_tx,
  output logic               out_busy,
  output logic               out_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  state_t               state_q, state_d;
  logic [7:0]           tick_q, tick_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic accept;
  logic bit_end;

  assign accept  = tx_bus.in_valid && (state_q == ST_IDLE);
  assign bit_end = in_clock_ena && (tick_q == TICK_LAST);

  always_ff @(posedge in_sys_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    // The strobe coinciding with accept is deliberately not counted.
    if ((state_q != ST_IDLE) && in_clock_ena) begin
      tick_d = bit_end ? 8'd0 : tick_q + 8'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          shift_d    = tx_bus.in_data;
          parity_d   = ^tx_bus.in_data;
          tick_d     = 8'd0;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = ST_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
              state_d    = ST_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = ST_STOP;
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx_bus.out_ready = (state_q == ST_IDLE);
  assign out_busy         = (state_q != ST_IDLE);
  assign out_tx           = tx_q;
  assign out_done         = done_q;

endmodule

// File: tb/tb_uart_tx_ce.sv
// Directed bench for uart_tx_ce: four instances cover 8N1, 8E1, 8N2 and 5N1 with a constant enable.
`timescale 1ns/1ps
module tb_uart_tx_ce;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       ph = 1'b0;
  logic [3:0] ena_v = '0;
  logic [3:0] valid_v;
  logic [3:0] stall_v;
  logic [7:0] data_v [4];
  wire  [3:0] tx_v, busy_v, done_v, rdy_v;

  int n_tests = 0;
  int n_fail  = 0;

  // Instances 0..2 get a strobe every other clock, instance 3 a constant enable.
  always @(negedge clk) begin
    ph = ~ph;
    for (int i = 0; i < 4; i++)
      ena_v[i] = stall_v[i] ? 1'b0 : ((i == 3) ? 1'b1 : ph);
  end

  uart_tx_ce_if #(.DATA_BITS(8)) if_a ();
  uart_tx_ce_if #(.DATA_BITS(8)) if_p ();
  uart_tx_ce_if #(.DATA_BITS(8)) if_s ();
  uart_tx_ce_if #(.DATA_BITS(5)) if_c ();

  assign if_a.in_data  = data_v[0];
  assign if_a.in_valid = valid_v[0];
  assign rdy_v[0]      = if_a.out_ready;
  assign if_p.in_data  = data_v[1];
  assign if_p.in_valid = valid_v[1];
  assign rdy_v[1]      = if_p.out_ready;
  assign if_s.in_data  = data_v[2];
  assign if_s.in_valid = valid_v[2];
  assign rdy_v[2]      = if_s.out_ready;
  assign if_c.in_data  = data_v[3][4:0];
  assign if_c.in_valid = valid_v[3];
  assign rdy_v[3]      = if_c.out_ready;

  uart_tx_ce #(.DATA_BITS(8), .TICKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_a (
    .in_sys_clk(clk), .in_rst_n(rst_n), .in_clock_ena(ena_v[0]), .tx_bus(if_a.slave),
    .out_tx(tx_v[0]), .out_busy(busy_v[0]), .out_done(done_v[0]));

  uart_tx_ce #(.DATA_BITS(8), .TICKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_p (
    .in_sys_clk(clk), .in_rst_n(rst_n), .in_clock_ena(ena_v[1]), .tx_bus(if_p.slave),
    .out_tx(tx_v[1]), .out_busy(busy_v[1]), .out_done(done_v[1]));

  uart_tx_ce #(.DATA_BITS(8), .TICKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) u_s (
    .in_sys_clk(clk), .in_rst_n(rst_n), .in_clock_ena(ena_v[2]), .tx_bus(if_s.slave),
    .out_tx(tx_v[2]), .out_busy(busy_v[2]), .out_done(done_v[2]));

  uart_tx_ce #(.DATA_BITS(5), .TICKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(1)) u_c (
    .in_sys_clk(clk), .in_rst_n(rst_n), .in_clock_ena(ena_v[3]), .tx_bus(if_c.slave),
    .out_tx(tx_v[3]), .out_busy(busy_v[3]), .out_done(done_v[3]));

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends one byte on instance d and decodes the line by counting strobes after accept.
  task automatic run_frame(input int d, input logic [7:0] data, input int tpb, input int nbits,
                           input logic [15:0] exp_bits, input int lat_lo, input int lat_hi,
                           input bit pre_acc, input bit hold_valid, input logic [7:0] next_data,
                           input int inj_at, input int stall_at, input string tag);
    int n, s, wait_n, hold_bad, stall_left;
    logic [15:0] got;
    logic hold_tx;
    bit seen_done;
    got = '0; s = 0; hold_bad = 0; stall_left = 0; hold_tx = 1'b1; seen_done = 1'b0;
    if (!pre_acc) begin
      wait_n = 0;
      while (!rdy_v[d] && wait_n < 500) begin
        tick();
        wait_n++;
      end
      chk({tag, "_ready"}, 32'(rdy_v[d]), 32'd1);
      data_v[d]  = data;
      valid_v[d] = 1'b1;
    end
    tick();
    valid_v[d] = hold_valid;
    data_v[d]  = hold_valid ? next_data : ~data;
    chk({tag, "_start"}, {29'd0, tx_v[d], busy_v[d], rdy_v[d]}, 32'b010);
    n = 1;
    while (!seen_done && n < 3000) begin
      if (done_v[d]) begin
        seen_done = 1'b1;
      end else begin
        if (ena_v[d]) begin
          if ((s % tpb) == (tpb / 2) && (s / tpb) < 16) got[s / tpb] = tx_v[d];
          s++;
        end
        if (stall_left > 0) begin
          if (stall_left == 50) hold_tx = tx_v[d];
          else if (tx_v[d] !== hold_tx) hold_bad++;
          stall_left--;
          if (stall_left == 0) stall_v[d] = 1'b0;
        end
        if (stall_at > 0 && n == stall_at) begin
          stall_v[d] = 1'b1;
          stall_left = 50;
        end
        if (inj_at > 0 && n == inj_at) begin
          valid_v[d] = 1'b1;
          data_v[d]  = 8'hFF;
        end else if (inj_at > 0 && n == inj_at + 1) begin
          valid_v[d] = 1'b0;
        end
        tick();
        n++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    chk({tag, "_bits"}, 32'(got), 32'(exp_bits));
    chk({tag, "_strobes"}, 32'(s), 32'(nbits * tpb));
    chk({tag, "_ready_at_done"}, {30'd0, rdy_v[d], busy_v[d]}, 32'b10);
    if (lat_hi > 0)
      chk({tag, "_latency"}, 32'((n - 1 >= lat_lo) && (n - 1 <= lat_hi)), 32'd1);
    if (stall_at > 0)
      chk({tag, "_stall_hold"}, 32'(hold_bad), 32'd0);
    if (!hold_valid) begin
      tick();
      chk({tag, "_done_pulse"}, {30'd0, done_v[d], tx_v[d]}, 32'b01);
    end
  endtask

  initial begin
    int bad;
    rst_n   = 1'b0;
    valid_v = '0;
    stall_v = '0;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
    tick();
    tick();
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset_state%0d", i), {28'd0, tx_v[i], rdy_v[i], busy_v[i], done_v[i]}, 32'b1100);
    rst_n = 1'b1;
    tick();

    // Reset during the start bit with in_valid still high.
    data_v[0]  = 8'hA5;
    valid_v[0] = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_pre_busy", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {28'd0, tx_v[0], rdy_v[0], busy_v[0], done_v[0]}, 32'b1100);
    tick();
    valid_v[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    chk("rst_no_frame", 32'(bad), 32'd0);

    run_frame(0, 8'hA5, 4, 10, 16'h034A, 79, 80, 1'b0, 1'b0, 8'h00, 0, 0, "basic_a5");
    run_frame(1, 8'hA5, 4, 11, 16'h054A, 87, 88, 1'b0, 1'b0, 8'h00, 0, 0, "par_a5");
    run_frame(1, 8'h07, 4, 11, 16'h060E, 87, 88, 1'b0, 1'b0, 8'h00, 0, 0, "par_07");
    run_frame(2, 8'h55, 4, 11, 16'h06AA, 87, 88, 1'b0, 1'b1, 8'h0F, 0, 0, "b2b_55");
    run_frame(2, 8'h0F, 4, 11, 16'h061E, 87, 88, 1'b1, 1'b0, 8'h00, 0, 0, "b2b_0f");
    run_frame(0, 8'hA5, 4, 10, 16'h034A, 129, 130, 1'b0, 1'b0, 8'h00, 20, 40, "rej_stall");
    run_frame(3, 8'h13, 2, 7, 16'h0066, 14, 14, 1'b0, 1'b0, 8'h00, 0, 0, "d5_13");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
